// File: rtl/calculator_seq_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier with start/busy/done handshake.
// Define CALC_SEQ_MULT_SIGNED_EN to build the optional two's-complement mode.
module calculator_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_in;
    logic [2*WIDTH-1:0] raw_product, final_product;

`ifdef CALC_SEQ_MULT_SIGNED_EN
    logic sign_a, sign_b;

    // Magnitudes fit WIDTH bits unsigned, including the most negative value.
    always_comb begin
        sign_a        = signed_mode & a_in[WIDTH-1];
        sign_b        = signed_mode & b_in[WIDTH-1];
        a_mag         = sign_a ? (~a_in + WIDTH'(1)) : a_in;
        b_mag         = sign_b ? (~b_in + WIDTH'(1)) : b_in;
        neg_in        = sign_a ^ sign_b;
        raw_product   = {acc_q, mplier_q};
        final_product = neg_q ? (~raw_product + (2*WIDTH)'(1)) : raw_product;
    end
`else
    logic signed_mode_unused;
    assign signed_mode_unused = signed_mode;

    always_comb begin
        a_mag         = a_in;
        b_mag         = b_in;
        neg_in        = 1'b0;
        raw_product   = {acc_q, mplier_q};
        final_product = raw_product;
    end
`endif

    // Carry of the partial-product add is kept and shifted into the accumulator.
    assign sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = neg_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d   = DONE;
                    product_d = final_product;
                end else begin
                    acc_d    = sum[WIDTH:1];
                    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_calculator_seq_multiplier.sv
// Self-checking bench: cycle-stamped behavioural model plus directed literal checks.
module tb_calculator_seq_multiplier;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           signed_mode = 1'b0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    calculator_seq_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
`ifdef CALC_SEQ_MULT_SIGNED_EN
        if (s && a[W-1]) x = x - (longint'(1) << W);
        if (s && b[W-1]) y = y - (longint'(1) << W);
`else
        if (s) x = x + 0;
`endif
        return (2*W)'(x * y);
    endfunction

    // Model: an accepted start at edge N gives done after edge N+W+1, idle after N+W+2.
    int             m_edge = 0;
    int             m_start = 0;
    bit             m_active = 1'b0;
    bit             m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge   <= 0;
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_prod   <= '0;
        end else begin
            m_edge <= m_edge + 1;
            m_done <= m_active && (m_edge + 1 == m_start + W + 1);
            if (m_active && (m_edge + 1 == m_start + W + 1)) m_prod <= m_pend;
            if (m_active && (m_edge + 1 == m_start + W + 2)) begin
                m_active <= 1'b0;
            end else if (!m_active && start) begin
                m_active <= 1'b1;
                m_start  <= m_edge + 1;
                m_pend   <= ref_mult(a_in, b_in, signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("product", product, m_prod);
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [2*W-1:0] p, output int lat);
        @(negedge clk); #1;
        a_in = a; b_in = b; signed_mode = s; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", done, 1'b1);
        p = product;
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [2*W-1:0] p;
        logic [2*W-1:0] got;
        int lat;
        int ndone;

        got = '0;
        check("model_ffff", ref_mult(16'hFFFF, 16'hFFFF, 1'b0), 64'hFFFE0001);
`ifdef CALC_SEQ_MULT_SIGNED_EN
        check("model_signed", ref_mult(16'h8000, 16'h0001, 1'b1), 64'hFFFF8000);
`else
        check("model_signed", ref_mult(16'h8000, 16'h0001, 1'b1), 64'h00008000);
`endif

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_product", product, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(16'h0003, 16'h0005, 1'b0, p, lat);
        check("lat_3x5", lat, 17);
        check("prod_3x5", p, 64'h0000000F);

        do_op(16'hFFFF, 16'hFFFF, 1'b0, p, lat);
        check("prod_ffff", p, 64'hFFFE0001);

        do_op(16'hFFFF, 16'h0002, 1'b1, p, lat);
`ifdef CALC_SEQ_MULT_SIGNED_EN
        check("prod_m1x2_s", p, 64'hFFFFFFFE);
`else
        check("prod_m1x2_s", p, 64'h0001FFFE);
`endif

        do_op(16'h8000, 16'h8000, 1'b1, p, lat);
        check("prod_min_min", p, 64'h40000000);
        do_op(16'h8000, 16'h0001, 1'b1, p, lat);
`ifdef CALC_SEQ_MULT_SIGNED_EN
        check("prod_min_1", p, 64'hFFFF8000);
`else
        check("prod_min_1", p, 64'h00008000);
`endif

        do_op(16'h0000, 16'hBEEF, 1'b0, p, lat);
        check("lat_zero", lat, 17);
        check("prod_zero", p, 64'h0);

        // Second start mid-RUN must be dropped.
        @(negedge clk); #1;
        a_in = 16'h0003; b_in = 16'h0005; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        a_in = 16'h1234; b_in = 16'h5678; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                got = product;
            end
        end
        check("repulse_done_count", ndone, 1);
        check("repulse_prod", got, 64'h0000000F);

        // Reset during RUN aborts and clears the held result.
        do_op(16'h0003, 16'h0005, 1'b0, p, lat);
        check("prior_prod", p, 64'h0000000F);
        @(negedge clk); #1;
        a_in = 16'h0007; b_in = 16'h0009; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_product", product, '0);
        check("abort_busy", busy, 1'b0);
        #1 rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(16'h0006, 16'h0007, 1'b0, p, lat);
        check("post_abort_prod", p, 64'h0000002A);

        repeat (1500) begin
            @(negedge clk); #1;
            start       = ($urandom_range(0, 3) == 0);
            a_in        = pick();
            b_in        = pick();
            signed_mode = 1'($urandom);
        end
        #1 start = 1'b0;
        repeat (W + 4) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
